osu_skid_buffer: RTL and testbench

Registered, ready/valid pipeline stage: the sequential counterpart to the drive-strength buffer cells. It retimes a data bus across one clock edge and absorbs back-pressure through a 2-entry skid (main plus skid register). It is inserted between generator-built macros and digital control paths to break long combinational A->Y routes while preserving full throughput.

---
 rtl/osu_skid_pkg.sv | 13 +
 rtl/osu_skid_reg.sv | 20 ++
 rtl/osu_skid_buffer.sv | 118 +++++++++++
 tb/tb_osu_skid_buffer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osu_skid_pkg.sv
// Shared types and constants for the osu_skid_buffer pipeline stage.
package osu_skid_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned STALL_W       = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/osu_skid_reg.sv
// WIDTH-bit data register with load enable and synchronous reset to zero.
module osu_skid_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/osu_skid_buffer.sv
// Registered ready/valid stage with a 2-entry (main + skid) buffer.
// Optional stall counter output enabled by defining OSU_SKID_STATS_EN.
module osu_skid_buffer
  import osu_skid_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               A_VALID,
  output logic               A_READY,
  input  logic [WIDTH-1:0]   A,
  output logic               Y_VALID,
  input  logic               Y_READY,
  output logic [WIDTH-1:0]   Y
`ifdef OSU_SKID_STATS_EN
  ,
  output logic [STALL_W-1:0] STALL_CNT
`endif
);

  skid_state_e      state;
  logic             in_fire;
  logic             out_fire;
  logic             main_load;
  logic             skid_load;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;

  assign in_fire  = A_VALID & A_READY;
  assign out_fire = Y_VALID & Y_READY;

  // Data-path load enables; the main register refills from skid when draining FULL.
  always_comb begin
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = A;
    case (state)
      EMPTY: main_load = in_fire;
      BUSY: begin
        main_load = in_fire & out_fire;
        skid_load = in_fire & ~out_fire;
      end
      FULL: begin
        main_load = out_fire;
        main_d    = skid_q;
      end
      default: ;
    endcase
  end

  osu_skid_reg #(.WIDTH(WIDTH)) u_main (
    .clk  (CLK),
    .rst  (RST),
    .load (main_load),
    .d    (main_d),
    .q    (Y)
  );

  osu_skid_reg #(.WIDTH(WIDTH)) u_skid (
    .clk  (CLK),
    .rst  (RST),
    .load (skid_load),
    .d    (A),
    .q    (skid_q)
  );

  // Control FSM; A_READY only falls once the skid entry is occupied.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= EMPTY;
      A_READY <= 1'b0;
      Y_VALID <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          A_READY <= 1'b1;
          if (in_fire) begin
            state   <= BUSY;
            Y_VALID <= 1'b1;
          end
        end
        BUSY: begin
          if (in_fire && !out_fire) begin
            state   <= FULL;
            A_READY <= 1'b0;
          end else if (!in_fire && out_fire) begin
            state   <= EMPTY;
            Y_VALID <= 1'b0;
          end
        end
        FULL: begin
          if (out_fire) begin
            state   <= BUSY;
            A_READY <= 1'b1;
          end
        end
        default: begin
          state   <= EMPTY;
          A_READY <= 1'b1;
          Y_VALID <= 1'b0;
        end
      endcase
    end
  end

`ifdef OSU_SKID_STATS_EN
  // Saturating count of edges where downstream withholds ready.
  always_ff @(posedge CLK) begin
    if (RST) begin
      STALL_CNT <= '0;
    end else if (Y_VALID && !Y_READY && (STALL_CNT != {STALL_W{1'b1}})) begin
      STALL_CNT <= STALL_CNT + STALL_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_osu_skid_buffer.sv
// Self-checking bench for osu_skid_buffer against a queue-based reference model.
module tb_osu_skid_buffer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         a_valid;
  logic         a_ready;
  logic [W-1:0] a;
  logic         y_valid;
  logic         y_ready;
  logic [W-1:0] y;
`ifdef OSU_SKID_STATS_EN
  logic [15:0]  stall_cnt;
`endif

  always #5 clk = ~clk;

  osu_skid_buffer #(.WIDTH(W)) dut (
    .CLK       (clk),
    .RST       (rst),
    .A_VALID   (a_valid),
    .A_READY   (a_ready),
    .A         (a),
    .Y_VALID   (y_valid),
    .Y_READY   (y_ready),
    .Y         (y)
`ifdef OSU_SKID_STATS_EN
    ,
    .STALL_CNT (stall_cnt)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: FIFO of held words (capacity 2), last front word, ready flag.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_last  = '0;
  logic         m_ready = 1'b0;
  // Words the DUT actually handed downstream.
  logic [W-1:0] got[$];

  function automatic logic m_valid();
    return mq.size() > 0;
  endfunction

  function automatic logic [W-1:0] m_y();
    return (mq.size() > 0) ? mq[0] : m_last;
  endfunction

  // Advance one clock: model the handshakes, record DUT output transfers.
  task automatic step();
    logic in_f, out_f;
    logic [W-1:0] w;
    in_f  = a_valid && m_ready && !rst;
    out_f = m_valid() && y_ready && !rst;
    if (!rst && y_valid === 1'b1 && y_ready) got.push_back(y);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_last  = '0;
      m_ready = 1'b0;
    end else begin
      if (out_f) w = mq.pop_front();
      if (in_f) mq.push_back(a);
      if (mq.size() > 0) m_last = mq[0];
      m_ready = (mq.size() < 2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; a_valid = 1'b1; a = 8'hAA; y_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (y_valid !== 1'b0 || y !== 8'h00 || a_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d: valid=%b y=%h ready=%b, need 0/00/0", i, y_valid, y, a_ready);
      end
    end
    rst = 1'b0; a_valid = 1'b0;
    n_cmp++;
    if (a_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_gap: ready=%b need 0", a_ready);
    end
    step();
    n_cmp++;
    if (a_ready !== 1'b1 || y_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_rise: ready=%b valid=%b need 1/0", a_ready, y_valid);
    end
  endtask

  task automatic test_stream();
    int outs0;
    y_ready = 1'b1;
    got.delete();
    for (int i = 1; i <= 16; i++) begin
      a_valid = 1'b1; a = W'(i);
      step();
      n_cmp++;
      if (y_valid !== 1'b1 || y !== W'(i) || a_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stream w=%0d: valid=%b y=%h ready=%b, need 1/%h/1", i, y_valid, y, a_ready, W'(i));
      end
    end
    a_valid = 1'b0;
    outs0 = got.size();
    step();
    n_cmp++;
    if (got.size() != 16 || outs0 != 15 || y_valid !== 1'b0 || y !== 8'h10) begin
      n_fail++;
      $display("FAIL stream_drain: outs=%0d valid=%b y=%h, need 16/0/10", got.size(), y_valid, y);
    end
  endtask

  task automatic test_backpressure();
    y_ready = 1'b0; a_valid = 1'b1; a = 8'h11;
    step();
    n_cmp++;
    if (a_ready !== 1'b1 || y !== 8'h11 || y_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_first: ready=%b y=%h valid=%b need 1/11/1", a_ready, y, y_valid);
    end
    a = 8'h22;
    step();
    a_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (a_ready !== 1'b0 || y !== 8'h11 || y_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_full cyc=%0d: ready=%b y=%h valid=%b need 0/11/1", i, a_ready, y, y_valid);
      end
      step();
    end
    y_ready = 1'b1;
    step();
    n_cmp++;
    if (y !== 8'h22 || y_valid !== 1'b1 || a_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_drain1: y=%h valid=%b ready=%b need 22/1/1", y, y_valid, a_ready);
    end
    step();
    n_cmp++;
    if (y_valid !== 1'b0 || y !== 8'h22) begin
      n_fail++;
      $display("FAIL bp_drain2: valid=%b y=%h need 0/22", y_valid, y);
    end
  endtask

  task automatic test_alternating();
    logic [W-1:0] words[32];
    int idx;
    int cyc;
    for (int i = 0; i < 32; i++) words[i] = W'($urandom_range(0, 255));
    got.delete();
    idx = 0; cyc = 0;
    y_ready = 1'b1;
    while (got.size() < 32 && cyc < 400) begin
      a_valid = (idx < 32);
      a = (idx < 32) ? words[idx] : '0;
      if (a_valid && m_ready) idx++;
      step();
      y_ready = ~y_ready;
      cyc++;
      n_cmp++;
      if (y_valid !== m_valid() || y !== m_y() || a_ready !== m_ready) begin
        n_fail++;
        $display("FAIL alt_cycle %0d: valid=%b y=%h ready=%b, need %b/%h/%b",
                 cyc, y_valid, y, a_ready, m_valid(), m_y(), m_ready);
      end
    end
    a_valid = 1'b0;
    n_cmp++;
    if (got.size() != 32) begin
      n_fail++;
      $display("FAIL alt_count: got %0d words, need 32", got.size());
    end
    for (int i = 0; i < 32 && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== words[i]) begin
        n_fail++;
        $display("FAIL alt_order idx=%0d: got %h need %h", i, got[i], words[i]);
      end
    end
  endtask

  task automatic test_reset_full();
    int cyc;
    y_ready = 1'b0; a_valid = 1'b1; a = 8'h33;
    step();
    a = 8'h44;
    step();
    a_valid = 1'b0;
    n_cmp++;
    if (a_ready !== 1'b0 || y !== 8'h33) begin
      n_fail++;
      $display("FAIL rf_full: ready=%b y=%h need 0/33", a_ready, y);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if (y_valid !== 1'b0 || y !== 8'h00 || a_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rf_cleared: valid=%b y=%h ready=%b need 0/00/0", y_valid, y, a_ready);
    end
    got.delete();
    y_ready = 1'b1; a_valid = 1'b1; a = 8'h55;
    cyc = 0;
    while (got.size() < 1 && cyc < 20) begin
      if (a_valid && m_ready) begin
        step();
        a_valid = 1'b0;
      end else begin
        step();
      end
      cyc++;
    end
    a_valid = 1'b0;
    n_cmp++;
    if (got.size() < 1) begin
      n_fail++;
      $display("FAIL rf_first_out: timeout, no word out, need 55");
    end else if (got[0] !== 8'h55) begin
      n_fail++;
      $display("FAIL rf_first_out: got %h need 55", got[0]);
    end
  endtask

`ifdef OSU_SKID_STATS_EN
  task automatic test_stats();
    rst = 1'b1; a_valid = 1'b0; y_ready = 1'b0;
    step();
    rst = 1'b0;
    n_cmp++;
    if (stall_cnt !== 16'h0000) begin
      n_fail++;
      $display("FAIL stats_reset: cnt=%h need 0000", stall_cnt);
    end
    step();
    a_valid = 1'b1; a = 8'h5A;
    step();
    a_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if (stall_cnt !== 16'd5) begin
      n_fail++;
      $display("FAIL stats_count: cnt=%0d need 5", stall_cnt);
    end
    for (int i = 0; i < 70000; i++) step();
    n_cmp++;
    if (stall_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL stats_sat: cnt=%h need FFFF", stall_cnt);
    end
    for (int i = 0; i < 10; i++) step();
    n_cmp++;
    if (stall_cnt !== 16'hFFFF || y_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stats_hold: cnt=%h valid=%b need FFFF/1", stall_cnt, y_valid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if (stall_cnt !== 16'h0000) begin
      n_fail++;
      $display("FAIL stats_clear: cnt=%h need 0000", stall_cnt);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; a_valid = 1'b0; a = '0; y_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_alternating();
    test_reset_full();
`ifdef OSU_SKID_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
